// File: rtl/input_sr_pkg.sv
// Shared types and helpers for the input shift-register window.
// Error flag indices are used only when INPUT_SR_ERR_EN is defined.
package input_sr_pkg;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

    typedef logic [1:0] err_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/input_sr_pop_sel.sv
// Combinational pop arbiter: the highest-index requested port that is available wins.
// It also flags multiple requests and requests made to unavailable ports.
module input_sr_pop_sel
    import input_sr_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 4,
    localparam int CW       = cnt_w(DEPTH)
) (
    input  logic [NUM_PORTS-1:0] ren_i,
    input  logic [NUM_PORTS-1:0] avail_i,
    output logic [CW-1:0]        pop_o,
    output logic                 multi_o,
    output logic                 illegal_o
);

    always_comb begin
        pop_o     = '0;
        multi_o   = ($countones(ren_i) > 1);
        illegal_o = |(ren_i & ~avail_i);
        // Ascending scan, so the last legal hit is the highest index.
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ren_i[k] && avail_i[k]) begin
                pop_o = CW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/input_sr_window.sv
// Input shift register holding up to DEPTH words oldest-first, presenting a NUM_WORDS window
// and NUM_PORTS pop ports (port k pops k+1 words). Error flags are built only with INPUT_SR_ERR_EN.
module input_sr_window
    import input_sr_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WORDS  = 2,
    parameter int DEPTH      = 4,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            wen,
    input  logic [NUM_PORTS-1:0]            ren,
    output logic [NUM_PORTS-1:0]            avail,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] data_out,
    output logic [cnt_w(DEPTH)-1:0]         count,
    output err_t                            err
);

    localparam int CW = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [CW-1:0]         pop;
    logic [CW-1:0]         after_pop;
    logic                  push_ok;

    // Handshake: ren[k] is honoured only in a cycle where avail[k] is high; avail
    // depends on registered count alone, so a consumer may use it to form ren.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            avail[k] = (int'(count_q) >= ((NUM_WORDS > k + 1) ? NUM_WORDS : k + 1));
        end
    end

`ifdef INPUT_SR_ERR_EN
    logic multi;
    logic illegal;
    err_t err_q;

    input_sr_pop_sel #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH)
    ) u_pop_sel (
        .ren_i     (ren),
        .avail_i   (avail),
        .pop_o     (pop),
        .multi_o   (multi),
        .illegal_o (illegal)
    );

    // Flags are sticky; a flush cycle ignores wen/ren and so cannot raise them.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else if (!flush) begin
            if (wen && !push_ok) err_q[ERR_OVF] <= 1'b1;
            if (multi || illegal) err_q[ERR_UNF] <= 1'b1;
        end
    end

    assign err = err_q;
`else
    input_sr_pop_sel #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH)
    ) u_pop_sel (
        .ren_i     (ren),
        .avail_i   (avail),
        .pop_o     (pop),
        .multi_o   (),
        .illegal_o ()
    );

    assign err = '0;
`endif

    // The arbiter never grants more words than count holds, so this cannot wrap.
    assign after_pop = count_q - pop;
    assign push_ok   = wen && (int'(after_pop) < DEPTH);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if ((j == i + int'(pop)) && (j < int'(count_q))) begin
                    mem_d[i] = mem_q[j];
                end
            end
            if (push_ok && (int'(after_pop) == i)) begin
                mem_d[i] = data_in;
            end
        end
        count_d = push_ok ? after_pop + CW'(1) : after_pop;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_window
        assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
    end

    assign count = count_q;

endmodule

// File: tb/tb_input_sr_window.sv
// Directed bench for input_sr_window at default parameters (16/2/4/2).
// Expected err values are masked to zero when INPUT_SR_ERR_EN is not defined.
module tb_input_sr_window;

`ifdef INPUT_SR_ERR_EN
    localparam logic [1:0] ERR_MASK = 2'b11;
`else
    localparam logic [1:0] ERR_MASK = 2'b00;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic [15:0] data_in;
    logic        wen;
    logic [1:0]  ren;
    logic [1:0]  avail;
    logic [31:0] data_out;
    logic [2:0]  count;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        we;
        logic [15:0] d;
        logic [1:0]  rd;
        logic [2:0]  c;
        logic [1:0]  av;
        logic [31:0] dout;
        logic [1:0]  e;
    } vec_t;

    vec_t vq[$];

    logic [15:0] exp_q[$];
    logic [1:0]  pat [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01,
                              2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10};

    input_sr_window dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .data_in  (data_in),
        .wen      (wen),
        .ren      (ren),
        .avail    (avail),
        .data_out (data_out),
        .count    (count),
        .err      (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // driver: apply inputs on the falling edge, sample 1ns after the rising edge
    task automatic step(input logic r, input logic f, input logic w,
                        input logic [15:0] d, input logic [1:0] rd);
        @(negedge clk);
        reset   = r;
        flush   = f;
        wen     = w;
        data_in = d;
        ren     = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic f, input logic w, input logic [15:0] d,
                       input logic [1:0] rd, input logic [2:0] c, input logic [1:0] av,
                       input logic [31:0] dout, input logic [1:0] e);
        vq.push_back('{r, f, w, d, rd, c, av, dout, e});
    endtask

    initial begin
        int          sz;
        int          p;
        logic        ill;
        logic [1:0]  m_err;
        logic [15:0] w0;
        logic [15:0] w1;

        reset   = 1'b1;
        flush   = 1'b0;
        wen     = 1'b0;
        data_in = '0;
        ren     = '0;

        //   rst fl we data     ren    cnt avail data_out      err
        add(1, 0, 0, 16'h0000, 2'b00, 0, 2'b00, 32'h0000_0000, 2'b00);
        add(0, 0, 1, 16'h0011, 2'b00, 1, 2'b00, 32'h0000_0011, 2'b00);
        add(0, 0, 1, 16'h0022, 2'b00, 2, 2'b11, 32'h0022_0011, 2'b00);
        add(0, 0, 1, 16'h0033, 2'b01, 2, 2'b11, 32'h0033_0022, 2'b00);
        add(1, 0, 0, 16'h0000, 2'b00, 0, 2'b00, 32'h0000_0000, 2'b00);
        add(0, 0, 1, 16'h00A1, 2'b00, 1, 2'b00, 32'h0000_00A1, 2'b00);
        add(0, 0, 1, 16'h00B2, 2'b00, 2, 2'b11, 32'h00B2_00A1, 2'b00);
        add(0, 0, 1, 16'h00C3, 2'b00, 3, 2'b11, 32'h00B2_00A1, 2'b00);
        add(0, 0, 1, 16'h00D4, 2'b00, 4, 2'b11, 32'h00B2_00A1, 2'b00);
        add(0, 0, 0, 16'h0000, 2'b10, 2, 2'b11, 32'h00D4_00C3, 2'b00);
        add(0, 0, 0, 16'h0000, 2'b11, 0, 2'b00, 32'h0000_0000, 2'b10);
        add(1, 0, 0, 16'h0000, 2'b00, 0, 2'b00, 32'h0000_0000, 2'b00);
        add(0, 0, 1, 16'h0001, 2'b00, 1, 2'b00, 32'h0000_0001, 2'b00);
        add(0, 0, 1, 16'h0002, 2'b00, 2, 2'b11, 32'h0002_0001, 2'b00);
        add(0, 0, 1, 16'h0003, 2'b00, 3, 2'b11, 32'h0002_0001, 2'b00);
        add(0, 0, 1, 16'h0004, 2'b00, 4, 2'b11, 32'h0002_0001, 2'b00);
        add(0, 0, 1, 16'h00EE, 2'b00, 4, 2'b11, 32'h0002_0001, 2'b01);
        add(0, 0, 1, 16'h00EE, 2'b01, 4, 2'b11, 32'h0003_0002, 2'b01);
        add(0, 0, 0, 16'h0000, 2'b10, 2, 2'b11, 32'h00EE_0004, 2'b01);
        add(0, 0, 1, 16'h0055, 2'b10, 1, 2'b00, 32'h0000_0055, 2'b01);
        add(0, 0, 0, 16'h0000, 2'b01, 1, 2'b00, 32'h0000_0055, 2'b11);
        add(0, 1, 1, 16'h0077, 2'b01, 0, 2'b00, 32'h0000_0000, 2'b11);
        add(0, 0, 1, 16'h0088, 2'b00, 1, 2'b00, 32'h0000_0088, 2'b11);
        add(1, 0, 1, 16'h0099, 2'b00, 0, 2'b00, 32'h0000_0000, 2'b00);
        add(0, 0, 0, 16'h0000, 2'b10, 0, 2'b00, 32'h0000_0000, 2'b10);
        add(0, 1, 0, 16'h0000, 2'b00, 0, 2'b00, 32'h0000_0000, 2'b10);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].fl, vq[i].we, vq[i].d, vq[i].rd);
            check($sformatf("v%0d count", i), 32'(count), 32'(vq[i].c));
            check($sformatf("v%0d avail", i), 32'(avail), 32'(vq[i].av));
            check($sformatf("v%0d data_out", i), data_out, vq[i].dout);
            check($sformatf("v%0d err", i), 32'(err), 32'(vq[i].e & ERR_MASK));
        end

        // Inputs changed between edges must not reach data_out or count.
        @(negedge clk);
        wen     = 1'b1;
        data_in = 16'hFFFF;
        ren     = 2'b11;
        #1;
        check("comb_path data_out", data_out, 32'h0);
        check("comb_path count", 32'(count), 32'd0);

        // Streaming sequence against a queue model.
        step(1, 0, 0, 16'h0000, 2'b00);
        exp_q.delete();
        m_err = 2'b00;
        for (int i = 0; i < 12; i++) begin
            sz  = exp_q.size();
            p   = 0;
            ill = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (pat[i][k] && sz >= 2) p = k + 1;
                if (pat[i][k] && sz < 2) ill = 1'b1;
            end
            if (ill || pat[i] == 2'b11) m_err[1] = 1'b1;
            repeat (p) void'(exp_q.pop_front());
            if (exp_q.size() < 4) exp_q.push_back(16'h0300 + 16'(i));
            else m_err[0] = 1'b1;

            step(0, 0, 1, 16'h0300 + 16'(i), pat[i]);
            w0 = (exp_q.size() > 0) ? exp_q[0] : 16'h0;
            w1 = (exp_q.size() > 1) ? exp_q[1] : 16'h0;
            check($sformatf("s%0d count", i), 32'(count), 32'(exp_q.size()));
            check($sformatf("s%0d avail", i), 32'(avail), (exp_q.size() >= 2) ? 32'd3 : 32'd0);
            check($sformatf("s%0d data_out", i), data_out, {w1, w0});
            check($sformatf("s%0d err", i), 32'(err), 32'(m_err & ERR_MASK));
        end

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
